frog_move_ctrl: RTL
===================

// Module: frog_move_ctrl
// PURPOSE
//  Frog movement controller for the VGA frog game. Synchronises and debounces the four
//  active-low direction buttons and sequences tile hops on frame ticks. Handles deaths,
//  lives, wins and score, and drives frog_x/frog_y to the sprite renderer in VGADemo.
// PARAMETERS
//  H_RES      640     playfield width, pixels
//  V_RES      480     playfield height, pixels
//  TILE       32      hop distance, pixels; must be a multiple of HOP_FRAMES
//  HOP_FRAMES 4       frame_ticks per hop; each tick moves TILE/HOP_FRAMES px
//  DEB_CYCLES 250000  stable clk cycles needed to accept a button level
//  DEAD_FRAMES 60     frame_ticks spent in DEAD
//  LIVES      3       lives at reset, 1..7
//  START_X    304     spawn x, top-left pixel, tile aligned
//  START_Y    448     spawn y, top-left pixel, tile aligned
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-low reset
//  up         in   1   raw button, active-low, asynchronous
//  down       in   1   raw button, active-low, asynchronous
//  left       in   1   raw button, active-low, asynchronous
//  right      in   1   raw button, active-low, asynchronous
//  frame_tick in   1   one-clk pulse at start of vblank
//  hit        in   1   collision flag from renderer; sampled only on frame_tick
//  frog_x     out  10  frog top-left x
//  frog_y     out  10  frog top-left y
//  moving     out  1   hop in progress
//  dead       out  1   death animation active
//  game_over  out  1   lives exhausted
//  lives      out  3   remaining lives
//  score      out  8   completed crossings, saturates at 255
// BEHAVIOUR
//  Reset (reset==0 at posedge clk), all outputs and state:
//   frog=(START_X,START_Y), state=IDLE, lives=LIVES, score=0, moving=dead=game_over=0,
//   all debouncers cleared to released (1). Reset mid-hop or mid-DEAD aborts to these values.
//  Input path: 2-FF synchroniser per button, then a debouncer. The debounced level changes
//   only after the synced level holds DEB_CYCLES consecutive clks. A press event is a 1->0
//   debounced transition, one clk wide, 2+DEB_CYCLES+1 clks after the raw edge.
//  Simultaneous press events: priority up > down > left > right; the others are dropped.
//  Press events are not queued: ignored unless state==IDLE.
//  States:
//   IDLE: press event -> target = frog +/- TILE on one axis. If target leaves
//    [0,H_RES-TILE] x [0,V_RES-TILE], ignore the press and stay IDLE. Otherwise -> HOP,
//    moving=1 next clk, step counter=0. up decrements y.
//   HOP: on each frame_tick, frog moves TILE/HOP_FRAMES px toward target, counter++.
//    On the HOP_FRAMES-th tick the frog is exactly at target, moving=0, and state ->
//    IDLE; -> WIN instead if frog_y==0.
//   WIN: one clk. score+1 (saturating), frog=(START_X,START_Y), -> IDLE.
//   DEAD: dead=1, position frozen. Counts DEAD_FRAMES frame_ticks, then frog=start,
//    dead=0, and state -> IDLE, or -> OVER if lives==0.
//   OVER: game_over=1, position frozen. Held until reset.
//  hit: evaluated only when frame_tick=1 and state is IDLE or HOP. Priority over the
//   hop step on the same tick. Effect: lives-1, moving=0, -> DEAD.
//   Ignored in DEAD, WIN and OVER.
//  frame_tick with no press and no hit in IDLE: no effect.
//  All outputs are registered; no combinational input->output path.
// STRUCTURE
//  frog_defs.vh (shared with VGADemo and renderer): state encodings S_IDLE/S_HOP/S_WIN/
//   S_DEAD/S_OVER, direction codes, default TILE/H_RES/V_RES/START_* localparams.
//  Sub-module btn_debounce (params DEB_CYCLES; ports clk, reset, raw_n, level_n,
//   press), instantiated 4x; contains the synchroniser and counter.
//  Top level: priority encoder, bounds check, main FSM, hop/dead counters,
//   lives/score registers.
// TESTING (DEB_CYCLES=4, default geometry, frame_tick every 20 clks)
//  1 Reset: hold reset=0 for 10 clks -> frog (304,448), lives=3, score=0, flags 0.
//  2 up held 8 clks -> one press. Over 4 ticks frog_y goes 440,432,424,416; moving
//    falls with the 4th tick. A 3-clk glitch on up produces no move.
//  3 Bounds: from (0,y) press left -> no move, moving stays 0. up+right pressed
//    together -> only the up hop occurs.
//  4 Win: force a start at y=32, press up -> y reaches 0, score=1, frog back at
//    (304,448). Score 255 plus one win stays 255.
//  5 Death: hit=1 on a tick mid-hop -> dead=1, lives=2, frog frozen; after 60 ticks
//    frog at start, dead=0. Three deaths -> game_over=1, presses ignored.
//  6 Reset mid-HOP and mid-DEAD -> all reset values on the next clk; no residual press.

Source files
------------

// File: rtl/frog_move_ctrl_pkg.sv
// Shared definitions for the frog movement controller: FSM states, hop directions,
// default playfield geometry and a small counter-width helper.
package frog_move_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOP,
        S_WIN,
        S_DEAD,
        S_OVER
    } state_t;

    // Direction codes double as button indices, so lower code = higher priority.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int NUM_BTN        = 4;
    localparam int DEF_H_RES      = 640;
    localparam int DEF_V_RES      = 480;
    localparam int DEF_TILE       = 32;
    localparam int DEF_HOP_FRAMES = 4;
    localparam int DEF_DEB_CYCLES = 250000;
    localparam int DEF_DEAD_FRAMES = 60;
    localparam int DEF_LIVES      = 3;
    localparam int DEF_START_X    = 304;
    localparam int DEF_START_Y    = 448;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when a one-tile hop from pos stays inside [0, max_pos].
    function automatic logic hop_fits(input logic [10:0] pos, input logic [10:0] tile,
                                      input logic [10:0] max_pos, input logic dec);
        return dec ? (pos >= tile) : ((pos + tile) <= max_pos);
    endfunction

endpackage

// File: rtl/frog_move_ctrl_debounce.sv
// Button conditioner: 2-FF synchroniser, consecutive-sample debouncer and a one-clk
// press pulse on each debounced 1->0 transition.
module btn_debounce
    import frog_move_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic level_n,
    output logic press
);

    localparam int CNT_W = cnt_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_d_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            level_reg   <= 1'b1;
            level_d_reg <= 1'b1;
            press_reg   <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync1_reg   <= raw_n;
            sync2_reg   <= sync1_reg;
            level_d_reg <= level_reg;
            press_reg   <= level_d_reg & ~level_reg;
            // Any sample matching the current level restarts the stability count.
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level_n = level_reg;
    assign press   = press_reg;

endmodule

// File: rtl/frog_move_ctrl.sv
// Frog movement controller: debounced direction buttons start tile hops that advance
// on frame ticks; collisions, lives, wins and score are sequenced by one FSM.
module frog_move_ctrl
    import frog_move_ctrl_pkg::*;
#(
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int TILE        = DEF_TILE,
    parameter int HOP_FRAMES  = DEF_HOP_FRAMES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int DEAD_FRAMES = DEF_DEAD_FRAMES,
    parameter int LIVES       = DEF_LIVES,
    parameter int START_X     = DEF_START_X,
    parameter int START_Y     = DEF_START_Y
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       frame_tick,
    input  logic       hit,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic       moving,
    output logic       dead,
    output logic       game_over,
    output logic [2:0] lives,
    output logic [7:0] score
);

    localparam int HOP_W  = cnt_width(HOP_FRAMES);
    localparam int DEAD_W = cnt_width(DEAD_FRAMES);
    localparam logic [HOP_W-1:0]  HOP_LAST  = HOP_W'(HOP_FRAMES - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_FRAMES - 1);
    localparam logic [9:0]  STEP10  = 10'(TILE / HOP_FRAMES);
    localparam logic [9:0]  TILE10  = 10'(TILE);
    localparam logic [10:0] TILE11  = 11'(TILE);
    localparam logic [10:0] X_MAX11 = 11'(H_RES - TILE);
    localparam logic [10:0] Y_MAX11 = 11'(V_RES - TILE);
    localparam logic [9:0]  START_X10 = 10'(START_X);
    localparam logic [9:0]  START_Y10 = 10'(START_Y);
    localparam logic [2:0]  LIVES3    = 3'(LIVES);

    logic [NUM_BTN-1:0] raw_n;
    logic [NUM_BTN-1:0] level_n_vec;
    logic [NUM_BTN-1:0] press_vec;
    logic [NUM_BTN-1:0] press_ok;

    assign raw_n = {right, left, down, up};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk    (clk),
                .reset  (reset),
                .raw_n  (raw_n[gi]),
                .level_n(level_n_vec[gi]),
                .press  (press_vec[gi])
            );
            // A press only counts while its button is still debounced-held.
            assign press_ok[gi] = press_vec[gi] & ~level_n_vec[gi];
        end
    endgenerate

    state_t            state_reg;
    dir_t              dir_reg;
    logic [9:0]        x_reg;
    logic [9:0]        y_reg;
    logic [9:0]        tx_reg;
    logic [9:0]        ty_reg;
    logic [HOP_W-1:0]  step_cnt_reg;
    logic [DEAD_W-1:0] dead_cnt_reg;
    logic [2:0]        lives_reg;
    logic [7:0]        score_reg;
    logic              moving_reg;
    logic              dead_reg;
    logic              over_reg;

    logic       sel_valid;
    dir_t       sel_dir;
    logic [9:0] tgt_x;
    logic [9:0] tgt_y;
    logic       tgt_ok;
    logic [9:0] step_x;
    logic [9:0] step_y;

    // Walk from lowest to highest priority so the up button overwrites last.
    always_comb begin
        sel_valid = 1'b0;
        sel_dir   = DIR_UP;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press_ok[i]) begin
                sel_valid = 1'b1;
                sel_dir   = dir_t'(2'(i));
            end
        end
    end

    always_comb begin
        tgt_x  = x_reg;
        tgt_y  = y_reg;
        tgt_ok = 1'b0;
        case (sel_dir)
            DIR_UP: begin
                tgt_y  = y_reg - TILE10;
                tgt_ok = hop_fits({1'b0, y_reg}, TILE11, Y_MAX11, 1'b1);
            end
            DIR_DOWN: begin
                tgt_y  = y_reg + TILE10;
                tgt_ok = hop_fits({1'b0, y_reg}, TILE11, Y_MAX11, 1'b0);
            end
            DIR_LEFT: begin
                tgt_x  = x_reg - TILE10;
                tgt_ok = hop_fits({1'b0, x_reg}, TILE11, X_MAX11, 1'b1);
            end
            default: begin
                tgt_x  = x_reg + TILE10;
                tgt_ok = hop_fits({1'b0, x_reg}, TILE11, X_MAX11, 1'b0);
            end
        endcase
    end

    always_comb begin
        step_x = x_reg;
        step_y = y_reg;
        case (dir_reg)
            DIR_UP:    step_y = y_reg - STEP10;
            DIR_DOWN:  step_y = y_reg + STEP10;
            DIR_LEFT:  step_x = x_reg - STEP10;
            default:   step_x = x_reg + STEP10;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            dir_reg      <= DIR_UP;
            x_reg        <= START_X10;
            y_reg        <= START_Y10;
            tx_reg       <= START_X10;
            ty_reg       <= START_Y10;
            step_cnt_reg <= '0;
            dead_cnt_reg <= '0;
            lives_reg    <= LIVES3;
            score_reg    <= '0;
            moving_reg   <= 1'b0;
            dead_reg     <= 1'b0;
            over_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (frame_tick && hit) begin
                        lives_reg    <= lives_reg - 3'd1;
                        dead_reg     <= 1'b1;
                        dead_cnt_reg <= '0;
                        state_reg    <= S_DEAD;
                    end else if (sel_valid && tgt_ok) begin
                        tx_reg       <= tgt_x;
                        ty_reg       <= tgt_y;
                        dir_reg      <= sel_dir;
                        step_cnt_reg <= '0;
                        moving_reg   <= 1'b1;
                        state_reg    <= S_HOP;
                    end
                end
                S_HOP: begin
                    if (frame_tick) begin
                        if (hit) begin
                            lives_reg    <= lives_reg - 3'd1;
                            moving_reg   <= 1'b0;
                            dead_reg     <= 1'b1;
                            dead_cnt_reg <= '0;
                            state_reg    <= S_DEAD;
                        end else if (step_cnt_reg == HOP_LAST) begin
                            // Snap to target so rounding can never leave the frog off-grid.
                            x_reg      <= tx_reg;
                            y_reg      <= ty_reg;
                            moving_reg <= 1'b0;
                            state_reg  <= (ty_reg == 10'd0) ? S_WIN : S_IDLE;
                        end else begin
                            x_reg        <= step_x;
                            y_reg        <= step_y;
                            step_cnt_reg <= step_cnt_reg + HOP_W'(1);
                        end
                    end
                end
                S_WIN: begin
                    score_reg <= (score_reg == 8'hFF) ? score_reg : score_reg + 8'd1;
                    x_reg     <= START_X10;
                    y_reg     <= START_Y10;
                    state_reg <= S_IDLE;
                end
                S_DEAD: begin
                    if (frame_tick) begin
                        if (dead_cnt_reg == DEAD_LAST) begin
                            x_reg    <= START_X10;
                            y_reg    <= START_Y10;
                            dead_reg <= 1'b0;
                            if (lives_reg == 3'd0) begin
                                over_reg  <= 1'b1;
                                state_reg <= S_OVER;
                            end else begin
                                state_reg <= S_IDLE;
                            end
                        end else begin
                            dead_cnt_reg <= dead_cnt_reg + DEAD_W'(1);
                        end
                    end
                end
                S_OVER: begin
                    over_reg <= 1'b1;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign frog_x    = x_reg;
    assign frog_y    = y_reg;
    assign moving    = moving_reg;
    assign dead      = dead_reg;
    assign game_over = over_reg;
    assign lives     = lives_reg;
    assign score     = score_reg;

endmodule
